// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin owner of a shared WIDTH-bit register with a hold-time limit
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] data_i,
  output logic [3:0]         gnt_o,
  output logic [1:0]         owner_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [WIDTH-1:0]   q_o
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);
  logic [0:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       win;
  // round-robin search: last+1 first, last itself last; the descending loop leaves the nearest hit
  always_comb begin
    win = last_q;
    for (int i = 4; i >= 1; i--)
      if (req_i[2'(last_q + 2'(i))]) win = 2'(last_q + 2'(i));
  end
  // next-state: grant from IDLE, reload while owner requests and the hold limit is not reached
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    data_d    = data_q;
    if (state_q == S_IDLE) begin
      if (|req_i) begin
        state_d = S_GRANT;
        gnt_d   = 4'b0001 << win;
        owner_d = win;
        last_d  = win;
        cnt_d   = 8'd1;
        data_d  = data_i[win*WIDTH +: WIDTH];
      end
    end else if (req_i[owner_q] && cnt_q < MAX_CNT) begin
      cnt_d  = cnt_q + 8'd1;
      data_d = data_i[owner_q*WIDTH +: WIDTH];
    end else begin
      state_d   = S_IDLE;
      gnt_d     = 4'b0000;
      timeout_d = req_i[owner_q];
    end
  end
  // state and shared register bank; reset aborts any grant at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
    end
  end
  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign busy_o    = state_q == S_GRANT;
  assign timeout_o = timeout_q;
  assign q_o       = data_q;
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit storage register, a bank of D flip-flops that four requesters share. It grants exclusive ownership to one requester at a time and loads the shared register with that owner's data while the grant is held. A hold-time limit stops any requester from monopolising the register. It sits between the requester logic and the shared register bank, which is implemented inside this block.

## Interface
- WIDTH, 8, width of the shared register and of each requester's data slice
- MAX_HOLD, 16, maximum consecutive cycles a grant is held (legal range 2..255)

- clk_i  in  1  system clock, rising edge
- rst_i  in  1  one clock; reset is asynchronous and active-low
- req_i  in  4  request lines, one per requester; bit k = requester k
- data_i  in  4*WIDTH  requester data; slice [k*WIDTH +: WIDTH] belongs to requester k
- gnt_o  out  4  one-hot grant, registered; all zero when no owner
- owner_o  out  2  index of the current owner; holds the last owner when idle
- busy_o  out  1  high while in GRANT
- timeout_o  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
- q_o  out  WIDTH  shared register contents

## Operation
- State machine has two states: IDLE and GRANT.
- Pointer last (2 bits) records the most recent owner.
- IDLE:
  - If req_i is nonzero, the winner is the first set bit when searching last+1, last+2, last+3, last (mod 4).
  - Next state is GRANT with gnt_o set to the winner's one-hot, owner_o and last set to the winner, hold counter set to 1, and q_o loaded with the winner's slice.
  - If req_i is zero, stay in IDLE; q_o holds its value.
- GRANT:
  - While req_i[owner] = 1 and hold counter < MAX_HOLD, q_o reloads from the owner's slice every cycle and the counter increments.
  - If req_i[owner] = 0, go to IDLE and clear gnt_o. q_o keeps the last loaded value; this cycle does not load.
  - If req_i[owner] = 1 and the counter = MAX_HOLD, go to IDLE, clear gnt_o and pulse timeout_o; q_o does not load.
- Every release path passes through IDLE for at least one cycle, so grants to different owners never overlap or abut.
- Requests from non-owners during GRANT are ignored; they are evaluated only in IDLE.
- A requester that was revoked by timeout and still requests re-competes normally. Because last = that requester, it has lowest priority.
- The hold counter is 8 bits; no wrap can occur within the legal MAX_HOLD range.
- Reset values (asynchronous, rst_i = 0):
  - state = IDLE
  - gnt_o = 4'b0000, owner_o = 2'd0, busy_o = 0, timeout_o = 0, q_o = 0
  - last = 2'd3, so requester 0 has first priority after reset.
- Reset asserted mid-GRANT aborts the grant immediately, without waiting for a clock edge; every output returns to its reset value.

## Timing
- Grant latency: req_i sampled high at edge N in IDLE → gnt_o, busy_o and q_o valid after edge N.
- Owner data sampled at edge M appears on q_o after edge M; one-cycle latency.
- Release: req_i[owner] sampled low at edge R → gnt_o = 0 after R. The earliest next grant is after R+1.
- Timeout: with req held, gnt_o is high for exactly MAX_HOLD cycles. timeout_o is high for the single cycle following the revoking edge.
- Maximum grant rate: one new grant every 2 cycles (GRANT then IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Deassertion of rst_i is assumed synchronous to clk_i, handled externally. The first active edge after deassertion already evaluates req_i.

## Test plan
- Reset with req_i = 4'b1111 → gnt_o = 0000, q_o = 0, owner_o = 0. After release, the first edge gives gnt_o = 0001.
- req_i = 4'b1111 held, data slices 0x11/0x22/0x33/0x44, MAX_HOLD = 4:
  - grants rotate 0, 1, 2, 3, 0, each lasting 4 cycles;
  - one idle cycle and a timeout_o pulse between grants;
  - q_o shows each owner's value.
- Single request req_i = 4'b0100 for 3 cycles, then low → gnt_o = 0100 for 3 cycles and q_o = slice 2. q_o holds after release; busy_o falls one cycle after req drops.
- During a grant to requester 1, raise req_i[0] → no change to gnt_o until 1 releases. After the idle cycle, gnt_o = 0001.
- Change data_i slice of the owner every cycle (0xA0, 0xA1, 0xA2) → q_o follows with one-cycle latency. A non-owner slice change has no effect.
- Assert rst_i low asynchronously mid-GRANT, between edges → gnt_o, busy_o and q_o clear immediately. last = 3 afterward, so requester 0 wins first.
